clock_domain_export_fifo: RTL and testbench

// Buffered successor of the single-word toggle exporter. Queues up to DEPTH

---
 rtl/clock_domain_export_fifo.sv | 162 ++++++++++++++++
 tb/tb_clock_domain_export_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_domain_export_fifo.sv
// -----------------------------------------------------------------------------
// clock_domain_export_fifo
//
// Purpose:
//   Queues words from the local clock domain in a small FIFO. Words leave one
//   at a time over a req/ack toggle handshake to a receiver in another clock
//   domain. The source only has to wait when the FIFO is full, not while a
//   word is crossing.
//
// Handshake (toggle protocol, one comment for the whole block):
//   - Local push side: stb is a one-cycle request. A word is accepted on an
//     edge where stb && ready. When stb && !ready, the word is dropped and the
//     sticky overflow flag is set.
//   - Cross-domain side: a launch updates handshake_data and toggles
//     handshake_req on the same edge. handshake_data then stays stable until
//     the next launch. The receiver signals completion by making handshake_ack
//     equal to handshake_req. The next launch waits until the synchronised ack
//     matches req.
//
// Ports:
//   clk             in   1                local clock; all logic on posedge
//   rst             in   1                synchronous reset, active-high
//   data            in   SIZE             word to queue
//   stb             in   1                one-cycle push request
//   ready           out  1                FIFO not full; a push is accepted
//   level           out  $clog2(DEPTH+1)  words queued, excluding in-flight
//   overflow        out  1                sticky: stb seen while ready=0
//   idle            out  1                settled, empty, nothing in flight
//   handshake_data  out  SIZE             word presented to the other domain
//   handshake_req   out  1                toggles once per launched word
//   handshake_ack   in   1                receiver toggle (async to clk)
// -----------------------------------------------------------------------------
module clock_domain_export_fifo #(
  parameter int SIZE        = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SIZE-1:0]            data,
  input  logic                       stb,
  output logic                       ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       idle,
  output logic [SIZE-1:0]            handshake_data,
  output logic                       handshake_req,
  input  logic                       handshake_ack
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(SYNC_STAGES + 1);

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [CW-1:0] SETTLE_L = CW'(SYNC_STAGES);

  // Storage and pointers
  logic [SIZE-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;

  // Handshake side
  logic [SIZE-1:0]        hs_data_q, hs_data_d;
  logic                   hs_req_q, hs_req_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          settle_q, settle_d;

  logic ack_sync;
  logic in_flight;
  logic settled;
  logic push;
  logic pop;

  assign ack_sync  = sync_q[SYNC_STAGES-1];
  assign in_flight = (hs_req_q != ack_sync);
  assign settled   = (settle_q == '0);

  // ready comes from the registered level only. A same-cycle pop does not
  // make room for a push into a full FIFO.
  assign ready = (level_q < DEPTH_L);
  assign push  = stb && ready;

  // A word pushed into an empty FIFO launches one edge later (no bypass),
  // because pop looks at the registered level.
  assign pop = settled && !in_flight && (level_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    hs_data_d  = hs_data_q;
    hs_req_d   = hs_req_q;
    settle_d   = settle_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], handshake_ack};

    // Hold off launches for SYNC_STAGES cycles after reset. This gives the
    // synchroniser time to fill with the live ack level, so a reset-time zero
    // cannot be mistaken for a completed handshake.
    if (!settled) begin
      settle_d = settle_q - CW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (stb && !ready) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      hs_data_d = mem_q[rd_ptr_q];
      hs_req_d  = !hs_req_q;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      hs_data_q  <= '0;
      hs_req_q   <= 1'b0;
      sync_q     <= '0;
      settle_q   <= SETTLE_L;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      hs_data_q  <= hs_data_d;
      hs_req_q   <= hs_req_d;
      sync_q     <= sync_d;
      settle_q   <= settle_d;
    end
  end

  // Storage needs no reset. The pointers and level decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign level          = level_q;
  assign overflow       = overflow_q;
  assign idle           = settled && (level_q == '0) && !in_flight;
  assign handshake_data = hs_data_q;
  assign handshake_req  = hs_req_q;

endmodule

// File: tb/tb_clock_domain_export_fifo.sv
module tb_clock_domain_export_fifo;

  localparam int SIZE        = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LW          = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] data = '0;
  logic            stb = 1'b0;
  logic            ready;
  logic [LW-1:0]   level;
  logic            overflow;
  logic            idle;
  logic [SIZE-1:0] handshake_data;
  logic            handshake_req;
  logic            handshake_ack = 1'b0;

  always #5 clk = ~clk;

  clock_domain_export_fifo #(
    .SIZE(SIZE), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .stb(stb),
    .ready(ready),
    .level(level),
    .overflow(overflow),
    .idle(idle),
    .handshake_data(handshake_data),
    .handshake_req(handshake_req),
    .handshake_ack(handshake_ack)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [SIZE-1:0] exp_q[$];
  logic mon_en   = 1'b0;
  logic req_prev = 1'b0;
  int   n_toggle = 0;

  // Every req toggle while monitoring must match the next expected word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && (handshake_req != req_prev)) begin
        n_vec++;
        n_toggle++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL launch_extra: got data %02h, expected no launch", handshake_data);
        end else begin
          logic [SIZE-1:0] e;
          e = exp_q.pop_front();
          if (handshake_data !== e) begin
            n_err++;
            $display("FAIL launch_order: got %02h, expected %02h", handshake_data, e);
          end
        end
      end
      req_prev = handshake_req;
    end
  end

  // ---------------- ack loopback driver ----------------
  logic lb_en   = 1'b0;
  logic lb_rand = 1'b0;
  int   lb_cnt  = 0;
  int   lb_dly  = 3;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (lb_en && (handshake_req != handshake_ack)) begin
        if (lb_cnt >= lb_dly) begin
          handshake_ack = handshake_req;
          lb_cnt = 0;
          lb_dly = lb_rand ? int'($urandom_range(0, 5)) : 3;
        end else begin
          lb_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks / checks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    stb = 1'b0;
    tick();
    tick();
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [SIZE-1:0] data;
    logic            stb;
    logic            ack;
    logic            e_ready;
    logic [LW-1:0]   e_level;
    logic            e_req;
    logic [SIZE-1:0] e_hd;
    logic            e_ov;
    logic            e_idle;
  } vec_t;

  vec_t vecs[13];

  initial begin
    //            data   stb   ack   rdy   lvl   req   hdata  ov    idle
    // Single word through an idle block, ack follows after 3 cycles.
    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b1};
    // Back-to-back pushes with ack frozen at 1: 0x01 launches, the next four
    // fill the FIFO, and 0x06 is dropped.
    vecs[6]  = '{8'h01, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[7]  = '{8'h02, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[8]  = '{8'h03, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[9]  = '{8'h04, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[10] = '{8'h05, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[11] = '{8'h06, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 8'h01, 1'b1, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    int budget;

    // Reset values, checked while rst is still asserted.
    tick();
    check_bit("rst_ready", ready, 1'b1);
    check_bit("rst_idle", idle, 1'b0);
    check_val("rst_level", 32'(level), 32'd0);
    check_bit("rst_req", handshake_req, 1'b0);
    check_val("rst_hdata", 32'(handshake_data), 32'h00);
    check_bit("rst_overflow", overflow, 1'b0);

    // Settle: idle rises SYNC_STAGES edges after reset is released.
    #1;
    rst = 1'b0;
    tick();
    check_bit("settle_not_yet", idle, 1'b0);
    tick();
    check_bit("settle_idle", idle, 1'b1);
    check_bit("settle_ready", ready, 1'b1);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      #1;
      data          = vecs[i].data;
      stb           = vecs[i].stb;
      handshake_ack = vecs[i].ack;
      tick();
      n_vec++;
      if (ready !== vecs[i].e_ready || level !== vecs[i].e_level ||
          handshake_req !== vecs[i].e_req || handshake_data !== vecs[i].e_hd ||
          overflow !== vecs[i].e_ov || idle !== vecs[i].e_idle) begin
        n_err++;
        $display("FAIL vec%0d: got rdy=%0b lvl=%0d req=%0b hd=%02h ov=%0b idle=%0b, expected rdy=%0b lvl=%0d req=%0b hd=%02h ov=%0b idle=%0b",
                 i, ready, level, handshake_req, handshake_data, overflow, idle,
                 vecs[i].e_ready, vecs[i].e_level, vecs[i].e_req, vecs[i].e_hd,
                 vecs[i].e_ov, vecs[i].e_idle);
      end
    end
    #1;
    stb = 1'b0;

    // Release the loopback: 0x02..0x05 drain in order, the dropped word never
    // appears.
    exp_q    = '{8'h02, 8'h03, 8'h04, 8'h05};
    req_prev = handshake_req;
    n_toggle = 0;
    mon_en   = 1'b1;
    lb_cnt   = 0;
    lb_dly   = 3;
    lb_en    = 1'b1;
    budget   = 0;
    while (!(exp_q.size() == 0 && idle) && budget < 300) begin
      tick();
      budget++;
    end
    check_bit("drain_timeout", budget < 300, 1'b1);
    repeat (10) tick();
    check_val("drain_toggles", 32'(n_toggle), 32'd4);
    check_val("drain_level", 32'(level), 32'd0);
    check_bit("drain_idle", idle, 1'b1);
    check_bit("drain_overflow_sticky", overflow, 1'b1);

    // Fill/drain 3*DEPTH words across pointer wrap, random ack delay.
    lb_rand  = 1'b1;
    n_toggle = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      budget = 0;
      while (!ready && budget < 100) begin
        tick();
        budget++;
      end
      check_bit("fill_ready_timeout", budget < 100, 1'b1);
      #1;
      data = 8'h40 + 8'(i);
      stb  = 1'b1;
      exp_q.push_back(8'h40 + 8'(i));
      tick();
      #1;
      stb = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    budget = 0;
    while (!(exp_q.size() == 0 && idle) && budget < 500) begin
      tick();
      budget++;
    end
    check_bit("wrap_timeout", budget < 500, 1'b1);
    repeat (10) tick();
    check_val("wrap_toggles", 32'(n_toggle), 32'(3 * DEPTH));
    check_bit("wrap_idle", idle, 1'b1);

    // Reset with a word in flight and ack held high by the receiver.
    mon_en  = 1'b0;
    lb_en   = 1'b0;
    lb_rand = 1'b0;
    #1;
    data = 8'h77;
    stb  = 1'b1;
    tick();
    #1;
    stb = 1'b0;
    tick();
    // A stale ack of 1 leaves a 0 req looking in flight after reset.
    handshake_ack = 1'b1;
    do_reset();
    tick();
    check_bit("mid_rst_req", handshake_req, 1'b0);
    check_val("mid_rst_level", 32'(level), 32'd0);
    check_bit("mid_rst_overflow", overflow, 1'b0);
    #1;
    data = 8'h11;
    stb  = 1'b1;
    tick();
    #1;
    data = 8'h22;
    tick();
    #1;
    stb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_bit("stall_req", handshake_req, 1'b0);
    end
    check_val("stall_level", 32'(level), 32'd2);
    check_bit("stall_idle", idle, 1'b0);

    // Receiver comes out of reset: launches resume with the first queued word.
    #1;
    handshake_ack = 1'b0;
    budget = 0;
    while (handshake_req == 1'b0 && budget < 20) begin
      tick();
      budget++;
    end
    check_bit("resume_req", handshake_req, 1'b1);
    check_val("resume_hdata", 32'(handshake_data), 32'h11);
    check_val("resume_level", 32'(level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
